multicycle_controller: RTL and testbench

Moore-style finite-state controller that sequences the multicycle MIPS `DataPath`. Each cycle it drives every `DataPath` control strobe. It reads back `op` and `funct` from the instruction register and steps through fetch, decode, execute, memory and writeback. It also takes external interrupt requests at instruction boundaries and raises `isInterrupted` towards the datapath.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared encodings for the multicycle MIPS controller and the DataPath ALU
// decoder: controller state enumeration, opcode constants, aluControl and
// aluSrcB selector encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Controller states; the encoding is visible on state_dbg.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_ILLEGAL = 4'd11,
    S_INTR    = 4'd12
  } state_t;

  // Opcodes understood by the controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // aluControl encodings (2'b11 is reserved and never driven).
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // aluSrcB encodings.
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // True for the last state of every instruction; irq is only sampled there.
  function automatic logic is_end_state(input state_t s);
    logic end_s;
    case (s)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_ILLEGAL: end_s = 1'b1;
      default:                                                  end_s = 1'b0;
    endcase
    return end_s;
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing the multicycle MIPS DataPath through fetch, decode,
// execute, memory and writeback, with interrupt entry at instruction
// boundaries. All strobes are decoded from the state register only.
//
// Ports:
//   clk           in  1  system clock, rising edge
//   rst           in  1  asynchronous active-high reset, forces FETCH
//   op            in  6  opcode from the instruction register
//   funct         in  6  function field (decoded by the DataPath ALU decoder)
//   irq           in  1  level interrupt request, sampled at end of instruction
//   aluControl    out 2  00 add, 01 sub, 10 from funct
//   aluSrcB       out 2  00 regB, 01 const 4, 10 simm, 11 simm<<2
//   ALUSrcA       out 1  0 PC, 1 register A
//   PCSource      out 1  0 ALU result, 1 ALUOut
//   PCWrite, isBranch, IRWrite, lorD, MemWrite, MemtoReg, RegWrite, RegDst,
//   isInterrupted out 1  DataPath strobes
//   illegal       out 1  high in the cycle after an unknown opcode is decoded
//   state_dbg     out 4  current state encoding
// -----------------------------------------------------------------------------
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       irq,
  output logic [1:0] aluControl,
  output logic [1:0] aluSrcB,
  output logic       ALUSrcA,
  output logic       PCSource,
  output logic       PCWrite,
  output logic       isBranch,
  output logic       IRWrite,
  output logic       lorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       isInterrupted,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state_q;
  state_t state_d;

  // funct is consumed by the DataPath ALU decoder, not by the sequencer.
  logic unused_funct_s;
  assign unused_funct_s = ^funct;

  // State register; reset abandons any partial instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    if (is_end_state(state_q)) begin
      // Instruction boundary: the only place an interrupt is taken.
      state_d = irq ? S_INTR : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            default:      state_d = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          // op is held by the IR; anything but lw/sw here is unreachable,
          // so fall back to a clean fetch rather than guess.
          if (op == OP_SW) begin
            state_d = S_MEMWR;
          end else if (op == OP_LW) begin
            state_d = S_MEMRD;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEMRD:  state_d = S_MEMWB;
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        S_INTR:   state_d = S_FETCH;
        default:  state_d = S_FETCH;  // unused encodings recover to FETCH
      endcase
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    aluControl    = ALU_ADD;
    aluSrcB       = SRCB_REGB;
    ALUSrcA       = 1'b0;
    PCSource      = 1'b0;
    PCWrite       = 1'b0;
    isBranch      = 1'b0;
    IRWrite       = 1'b0;
    lorD          = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    isInterrupted = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        aluSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM_SH2;  // branch target precomputed into ALUOut
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        lorD = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        lorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        aluControl = ALU_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        // PC update is gated by the DataPath zero flag via isBranch.
        ALUSrcA    = 1'b1;
        aluControl = ALU_SUB;
        isBranch   = 1'b1;
        PCSource   = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      S_INTR: begin
        isInterrupted = 1'b1;
        PCWrite       = 1'b1;
      end
      default: begin
        aluControl = ALU_ADD;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       irq = 1'b0;
  logic [1:0] aluControl, aluSrcB;
  logic       ALUSrcA, PCSource, PCWrite, isBranch, IRWrite, lorD;
  logic       MemWrite, MemtoReg, RegWrite, RegDst, isInterrupted, illegal;
  logic [3:0] state_dbg;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .irq(irq),
    .aluControl(aluControl), .aluSrcB(aluSrcB), .ALUSrcA(ALUSrcA),
    .PCSource(PCSource), .PCWrite(PCWrite), .isBranch(isBranch),
    .IRWrite(IRWrite), .lorD(lorD), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .RegDst(RegDst), .isInterrupted(isInterrupted),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [19:0] exp_q[$];
  state_t      seq_q[$];
  logic [19:0] mon_e;
  logic        last_irq;

  // Expected outputs of one state, straight from the state/output table.
  function automatic logic [19:0] exp_vec(input state_t s);
    logic [1:0] aluc = 2'b00;
    logic [1:0] srcb = 2'b00;
    logic a = 1'b0, pcs = 1'b0, pcw = 1'b0, br = 1'b0, irw = 1'b0, lord = 1'b0;
    logic mw = 1'b0, m2r = 1'b0, rw = 1'b0, rd = 1'b0, intr = 1'b0, ill = 1'b0;
    case (s)
      S_FETCH:   begin irw = 1'b1; pcw = 1'b1; srcb = 2'b01; end
      S_DECODE:  begin srcb = 2'b11; end
      S_MEMADR:  begin a = 1'b1; srcb = 2'b10; end
      S_MEMRD:   begin lord = 1'b1; end
      S_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:   begin lord = 1'b1; mw = 1'b1; end
      S_EXEC:    begin a = 1'b1; aluc = 2'b10; end
      S_ALUWB:   begin rw = 1'b1; rd = 1'b1; end
      S_BRANCH:  begin a = 1'b1; aluc = 2'b01; br = 1'b1; pcs = 1'b1; end
      S_ADDIEX:  begin a = 1'b1; srcb = 2'b10; end
      S_ADDIWB:  begin rw = 1'b1; end
      S_ILLEGAL: begin ill = 1'b1; end
      S_INTR:    begin intr = 1'b1; pcw = 1'b1; end
      default:   begin end
    endcase
    return {4'(s), aluc, srcb, a, pcs, pcw, br, irw, lord, mw, m2r, rw, rd, intr, ill};
  endfunction

  function automatic logic [19:0] act_vec();
    return {state_dbg, aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch,
            IRWrite, lorD, MemWrite, MemtoReg, RegWrite, RegDst, isInterrupted, illegal};
  endfunction

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h (t=%0t)", nm, act, exp, $time);
  endtask

  // Instruction state walk derived from opcode class.
  function automatic void build_seq(input logic [5:0] o);
    seq_q.delete();
    seq_q.push_back(S_FETCH);
    seq_q.push_back(S_DECODE);
    case (o)
      OP_LW:    begin seq_q.push_back(S_MEMADR); seq_q.push_back(S_MEMRD); seq_q.push_back(S_MEMWB); end
      OP_SW:    begin seq_q.push_back(S_MEMADR); seq_q.push_back(S_MEMWR); end
      OP_RTYPE: begin seq_q.push_back(S_EXEC);   seq_q.push_back(S_ALUWB); end
      OP_BEQ:   begin seq_q.push_back(S_BRANCH); end
      OP_ADDI:  begin seq_q.push_back(S_ADDIEX); seq_q.push_back(S_ADDIWB); end
      default:  begin seq_q.push_back(S_ILLEGAL); end
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) || (o == OP_BEQ) || (o == OP_ADDI);
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] r;
    case ($urandom_range(0, 5))
      0: r = OP_RTYPE;
      1: r = OP_LW;
      2: r = OP_SW;
      3: r = OP_BEQ;
      4: r = OP_ADDI;
      default: begin
        do r = 6'($urandom_range(0, 63)); while (is_legal(r));
      end
    endcase
    return r;
  endfunction

  // irq_mode: 0 low, 1 random per cycle, 2 held high, 3 high from third state on.
  task automatic run_instr(input logic [5:0] op_v, input int irq_mode);
    build_seq(op_v);
    last_irq = 1'b0;
    for (int i = 0; i < seq_q.size(); i++) begin
      op    = op_v;
      funct = 6'($urandom);
      case (irq_mode)
        1:       irq = ($urandom_range(0, 3) == 0);
        2:       irq = 1'b1;
        3:       irq = (i >= 2);
        default: irq = 1'b0;
      endcase
      exp_q.push_back(exp_vec(seq_q[i]));
      last_irq = irq;
      @(posedge clk); #1;
    end
    if (last_irq) begin
      if (irq_mode != 2) irq = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_vec(S_INTR));
      @(posedge clk); #1;
    end
  endtask

  // Monitor: one expected record per cycle, compared away from the edge.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle", act_vec(), mon_e);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", act_vec(), exp_vec(S_FETCH));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(OP_LW, 0);
    run_instr(OP_RTYPE, 0);
    run_instr(OP_BEQ, 0);
    run_instr(OP_SW, 3);
    run_instr(rand_op(), 2);
    run_instr(6'b111111, 0);
    run_instr(OP_ADDI, 0);
    for (int n = 0; n < 200; n++) run_instr(rand_op(), 1);
    irq = 1'b0;
    for (int n = 0; n < 20; n++) run_instr(rand_op(), 0);

    // Asynchronous reset during MEMWR of a store.
    build_seq(OP_SW);
    for (int i = 0; i < 3; i++) begin
      op = OP_SW;
      exp_q.push_back(exp_vec(seq_q[i]));
      @(posedge clk); #1;
    end
    exp_q.push_back(exp_vec(S_MEMWR));
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_reset", act_vec(), exp_vec(S_FETCH));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int n = 0; n < 20; n++) run_instr(rand_op(), 1);
    irq = 1'b0;
    @(negedge clk);
    check("queue_drained", 20'(exp_q.size()), 20'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
